// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t          : controller FSM encoding (RUN=0, MD_WAIT=1)
//   REG_ZERO, REG_RA : architectural register numbers of interest
//   *_DEFAULT        : default parameter values for the controller
package pipeline_hazard_controller_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int MULDIV_LAT_DEFAULT = 4;
    localparam int PERF_W_DEFAULT     = 16;

endpackage

// File: rtl/pipeline_hazard_controller_sat_perf_counter.sv
// Saturating event counter for pipeline statistics.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current count, holds at all-ones
module sat_perf_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline, sitting in ID.
// Detects load-use and branch/jr operand hazards, freezes the pipe for the
// duration of a multi-cycle mul/div in EX, and counts stalled cycles.
// Inputs : ID operand fields and branch/jr flags, EX/MEM destination info,
//          EX_MulDiv_start, Branch_or_jump_taken.
// Outputs: PCWrite, IFID_Write, IFID_Flush, IDEX_Write, Mux_Select_Stall,
//          MulDiv_busy, MulDiv_done, stall_cycles, fsm_state (debug view of
//          the controller state).
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int PERF_W     = PERF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_uses_rt,
    input  logic              ID_Branch,
    input  logic              ID_Jr,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [4:0]        EX_dest,
    input  logic              MEM_MemRead,
    input  logic [4:0]        MEM_dest,
    input  logic              EX_MulDiv_start,
    input  logic              Branch_or_jump_taken,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Write,
    output logic              Mux_Select_Stall,
    output logic              MulDiv_busy,
    output logic              MulDiv_done,
    output logic [PERF_W-1:0] stall_cycles,
    output state_t            fsm_state
);

    // The start cycle and the final (cnt==0) cycle are both part of the
    // window, so the down-counter starts two short of the total latency.
    localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu_haz, br_haz, md_freeze, md_last;

    // A branch compares rt as well as rs; jr only reads rs.
    function automatic logic match(input logic [4:0] r);
        return (r == ID_rs) || (ID_Branch && ID_uses_rt && (r == ID_rt));
    endfunction

    always_comb begin
        lu_haz = EX_MemRead && (EX_dest != REG_ZERO) &&
                 ((EX_dest == ID_rs) || (ID_uses_rt && (EX_dest == ID_rt)));
        // Branch operands are compared in ID, so any producer still in EX,
        // or a load still in MEM, has not yet reached the forwarding paths.
        br_haz = (ID_Branch || ID_Jr) &&
                 ((EX_RegWrite && (EX_dest != REG_ZERO) && match(EX_dest)) ||
                  (MEM_MemRead && (MEM_dest != REG_ZERO) && match(MEM_dest)));
    end

    assign md_freeze = (state_q == MD_WAIT) || EX_MulDiv_start;
    assign md_last   = (state_q == MD_WAIT) && (cnt_q == 4'd0);

    // Next state. EX_MulDiv_start stays high while ID/EX is frozen, so it
    // only opens a window from RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (EX_MulDiv_start) begin
                    state_d = MD_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            MD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs, highest priority first.
    always_comb begin
        PCWrite          = 1'b1;
        IFID_Write       = 1'b1;
        IDEX_Write       = 1'b1;
        Mux_Select_Stall = 1'b0;
        IFID_Flush       = 1'b0;
        MulDiv_busy      = 1'b0;
        MulDiv_done      = 1'b0;
        if (!rst_n) begin
            PCWrite          = 1'b0;
            IFID_Write       = 1'b0;
            IDEX_Write       = 1'b0;
            Mux_Select_Stall = 1'b1;
            IFID_Flush       = 1'b1;
        end else if (md_freeze) begin
            // Hold every stage in place; a bubble would lose the ID instruction.
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            MulDiv_busy = 1'b1;
            MulDiv_done = md_last;
        end else if (lu_haz || br_haz) begin
            // Redirect decision is based on stale operands, so it is ignored.
            PCWrite          = 1'b0;
            IFID_Write       = 1'b0;
            Mux_Select_Stall = 1'b1;
        end else if (Branch_or_jump_taken) begin
            IFID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fsm_state = state_q;

    sat_perf_counter #(
        .WIDTH (PERF_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n && !PCWrite),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_dest, MEM_dest;
  logic       ID_uses_rt, ID_Branch, ID_Jr, EX_MemRead, EX_RegWrite;
  logic       MEM_MemRead, EX_MulDiv_start, Branch_or_jump_taken;

  // instance a: defaults (LAT=4, PERF_W=16); instance b: LAT=2, PERF_W=2
  logic        pcw_a, ifw_a, fl_a, idw_a, mux_a, busy_a, done_a;
  logic [15:0] stall_a;
  state_t      st_a;
  logic        pcw_b, ifw_b, fl_b, idw_b, mux_b, busy_b, done_b;
  logic [1:0]  stall_b;
  state_t      st_b;

  pipeline_hazard_controller dut_a (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rt(ID_uses_rt), .ID_Branch(ID_Branch), .ID_Jr(ID_Jr),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_dest(EX_dest),
    .MEM_MemRead(MEM_MemRead), .MEM_dest(MEM_dest),
    .EX_MulDiv_start(EX_MulDiv_start), .Branch_or_jump_taken(Branch_or_jump_taken),
    .PCWrite(pcw_a), .IFID_Write(ifw_a), .IFID_Flush(fl_a), .IDEX_Write(idw_a),
    .Mux_Select_Stall(mux_a), .MulDiv_busy(busy_a), .MulDiv_done(done_a),
    .stall_cycles(stall_a), .fsm_state(st_a)
  );

  pipeline_hazard_controller #(.MULDIV_LAT(2), .PERF_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rt(ID_uses_rt), .ID_Branch(ID_Branch), .ID_Jr(ID_Jr),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_dest(EX_dest),
    .MEM_MemRead(MEM_MemRead), .MEM_dest(MEM_dest),
    .EX_MulDiv_start(EX_MulDiv_start), .Branch_or_jump_taken(Branch_or_jump_taken),
    .PCWrite(pcw_b), .IFID_Write(ifw_b), .IFID_Flush(fl_b), .IDEX_Write(idw_b),
    .Mux_Select_Stall(mux_b), .MulDiv_busy(busy_b), .MulDiv_done(done_b),
    .stall_cycles(stall_b), .fsm_state(st_b)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem[i]  : freeze cycles still owed after the current one (0 = no window)
  // cnt_m[i]: expected stall counter value
  int lat[2]   = '{4, 2};
  int maxc[2]  = '{65535, 3};
  int rem[2]   = '{0, 0};
  int cnt_m[2] = '{0, 0};

  // Expected output vector {PCWrite, IFID_Write, IFID_Flush, IDEX_Write,
  // Mux_Select_Stall, MulDiv_busy, MulDiv_done}.
  function automatic logic [6:0] model_out(input int r);
    logic lu, br, m_ex, m_mem;
    lu    = EX_MemRead && EX_dest != 0 &&
            (EX_dest == ID_rs || (ID_uses_rt && EX_dest == ID_rt));
    m_ex  = EX_dest == ID_rs || (ID_Branch && ID_uses_rt && EX_dest == ID_rt);
    m_mem = MEM_dest == ID_rs || (ID_Branch && ID_uses_rt && MEM_dest == ID_rt);
    br    = (ID_Branch || ID_Jr) &&
            ((EX_RegWrite && EX_dest != 0 && m_ex) || (MEM_MemRead && MEM_dest != 0 && m_mem));
    if (!rst_n)                     return 7'b0010100;
    if (r > 0 || EX_MulDiv_start)   return {6'b000001, r == 1};
    if (lu || br)                   return 7'b0001100;
    if (Branch_or_jump_taken)       return 7'b1111000;
    return 7'b1101000;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] act [2];
    logic [31:0] cnt_act [2];
    state_t st_act [2];
    act[0] = {pcw_a, ifw_a, fl_a, idw_a, mux_a, busy_a, done_a};
    act[1] = {pcw_b, ifw_b, fl_b, idw_b, mux_b, busy_b, done_b};
    cnt_act[0] = 32'(stall_a);
    cnt_act[1] = 32'(stall_b);
    st_act[0] = st_a;
    st_act[1] = st_b;
    for (int i = 0; i < 2; i++) begin
      e = model_out(rem[i]);
      check(i == 0 ? "outs_a" : "outs_b", 32'(act[i]), 32'(e));
      check(i == 0 ? "stall_cnt_a" : "stall_cnt_b", cnt_act[i], 32'(cnt_m[i]));
      check(i == 0 ? "state_a" : "state_b", 32'(st_act[i]), (rem[i] > 0) ? 32'(MD_WAIT) : 32'(RUN));
      // advance the model to what the next rising edge must produce
      if (!rst_n) begin
        rem[i]   = 0;
        cnt_m[i] = 0;
      end else begin
        if (!e[6] && cnt_m[i] < maxc[i]) cnt_m[i]++;
        if (rem[i] > 0)               rem[i]--;
        else if (EX_MulDiv_start)     rem[i] = lat[i] - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_Branch = 0; ID_Jr = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_dest = 0;
    MEM_MemRead = 0; MEM_dest = 0; EX_MulDiv_start = 0; Branch_or_jump_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    settle();
    check("rst_pcwrite", 32'(pcw_a), 0);
    check("rst_mux", 32'(mux_a), 1);
    check("rst_flush", 32'(fl_a), 1);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check("post_rst_pcwrite", 32'(pcw_a), 1);
    check("post_rst_stall", 32'(stall_a), 0);

    // load-use: lw $8 in EX, add reads $8
    tick(); EX_MemRead = 1; EX_RegWrite = 1; EX_dest = 8; ID_rs = 8;
    settle();
    check("lu_pcwrite", 32'(pcw_a), 0);
    check("lu_mux", 32'(mux_a), 1);
    tick(); idle(); MEM_MemRead = 1; MEM_dest = 8; ID_rs = 8;
    settle();
    check("lu_released", 32'(pcw_a), 1);
    tick(); idle(); EX_MemRead = 1; EX_dest = 0; ID_rs = 0;
    settle();
    check("lu_r0_nostall", 32'(pcw_a), 1);

    // load feeding a branch: two stalls, redirect ignored while stalled
    tick(); idle();
    EX_MemRead = 1; EX_RegWrite = 1; EX_dest = 9;
    ID_Branch = 1; ID_uses_rt = 1; ID_rt = 9; ID_rs = 4; Branch_or_jump_taken = 1;
    settle();
    check("lb_stall1_pcw", 32'(pcw_a), 0);
    check("lb_stall1_flush", 32'(fl_a), 0);
    tick(); EX_MemRead = 0; EX_RegWrite = 0; EX_dest = 0; MEM_MemRead = 1; MEM_dest = 9;
    settle();
    check("lb_stall2_pcw", 32'(pcw_a), 0);
    check("lb_stall2_flush", 32'(fl_a), 0);
    tick(); MEM_MemRead = 0; MEM_dest = 0;
    settle();
    check("lb_redirect_pcw", 32'(pcw_a), 1);
    check("lb_redirect_flush", 32'(fl_a), 1);

    // mul/div window, first cycle coinciding with load-use and redirect
    tick(); idle();
    tick(); EX_MulDiv_start = 1; EX_MemRead = 1; EX_dest = 8; ID_rs = 8; Branch_or_jump_taken = 1;
    settle();
    check("md1_pcw", 32'(pcw_a), 0);
    check("md1_idexw", 32'(idw_a), 0);
    check("md1_mux", 32'(mux_a), 0);
    check("md1_flush", 32'(fl_a), 0);
    check("md1_done", 32'(done_a), 0);
    for (int k = 2; k <= 4; k++) begin
      tick(); idle(); EX_MulDiv_start = 1;
      settle();
      check("md_pcw", 32'(pcw_a), 0);
      check("md_idexw", 32'(idw_a), 0);
      check("md_done", 32'(done_a), (k == 4) ? 1 : 0);
    end
    tick(); idle();
    settle();
    check("md_after_pcw", 32'(pcw_a), 1);
    check("md_after_busy", 32'(busy_a), 0);
    check("stall_total_a", 32'(stall_a), 7);
    check("stall_sat_b", 32'(stall_b), 3);

    // reset in the second MD_WAIT cycle
    tick(); EX_MulDiv_start = 1;
    tick();
    tick(); rst_n = 1'b0;
    settle();
    check("md_rst_busy", 32'(busy_a), 0);
    tick(); rst_n = 1'b1; EX_MulDiv_start = 0;
    settle();
    check("md_rst_state", 32'(st_a), 32'(RUN));
    check("md_rst_busy_after", 32'(busy_a), 0);
    check("md_rst_pcw_after", 32'(pcw_a), 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 63) != 0);
      ID_rs = pick_reg(); ID_rt = pick_reg();
      EX_dest = pick_reg(); MEM_dest = pick_reg();
      ID_uses_rt = 1'($urandom_range(0, 1));
      ID_Branch = ($urandom_range(0, 3) == 0);
      ID_Jr = !ID_Branch && ($urandom_range(0, 7) == 0);
      EX_MemRead = ($urandom_range(0, 2) == 0);
      EX_RegWrite = 1'($urandom_range(0, 1));
      MEM_MemRead = ($urandom_range(0, 2) == 0);
      EX_MulDiv_start = ($urandom_range(0, 15) == 0);
      Branch_or_jump_taken = ($urandom_range(0, 3) == 0);
    end
    tick(); idle(); rst_n = 1'b1;
    settle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
